// File: rtl/io_pkg.sv
// Shared definitions for the IO ports that sit on the 16-bit controller bus.
package io_pkg;

  // Width of the shared data bus and the default depth of port FIFOs
  localparam int BUS_W         = 16;
  localparam int IO_FIFO_DEPTH = 4;

  // One word as carried on the shared bus
  typedef logic [BUS_W-1:0] bus_word_t;

endpackage : io_pkg

// File: rtl/io_fifo_core.sv
// Generic register-array FIFO with push/pop strobes, occupancy count and
// full/empty flags. Push while full and pop while empty are ignored here, so
// callers can wire raw requests straight in.
module io_fifo_core
  import io_pkg::*;
#(
  parameter  int WIDTH = BUS_W,
  parameter  int DEPTH = IO_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  // Flags come straight from the registered count, so they describe the
  // state at the start of the cycle.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // The head word is read combinationally; an empty FIFO shows zero so the
  // output is clean after reset and never exposes stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

  // Next-state for pointers and occupancy; DEPTH is a power of two, so the
  // pointers wrap to zero through natural overflow.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset, so it has no reset
  always_ff @(posedge clk) begin
    if (doPush && !rst) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

endmodule : io_fifo_core

// File: rtl/io_out_port.sv
// Output port: captures bus words on the controller write strobe, buffers
// them, and hands them to a peripheral over a valid/ready handshake.
module io_out_port
  import io_pkg::*;
#(
  parameter  int WIDTH = BUS_W,
  parameter  int DEPTH = IO_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic             wEn,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             clrOvf,
  output logic [CNT_W-1:0] count
);

  logic overflow_q, overflow_d;
  logic popReq;

  // A transfer happens only when a word is actually being presented
  assign popReq   = outValid && outReady;
  assign outValid = !empty;
  assign overflow = overflow_q;

  io_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wEn),
    .wdata_i (bus),
    .pop_i   (popReq),
    .rdata_o (dataOut),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Sticky overflow: a write seen while full (start-of-cycle) sets it, and
  // setting takes priority over a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (clrOvf) begin
      overflow_d = 1'b0;
    end
    if (wEn && full) begin
      overflow_d = 1'b1;
    end
  end

  // Overflow flag register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

endmodule : io_out_port

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_io_out_port;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      bus;
  logic             wEn;
  logic [15:0]      dataOut;
  logic             outValid;
  logic             outReady;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             clrOvf;
  logic [CNT_W-1:0] count;

  logic [15:0] modelQ[$];
  logic        modelOvf;
  int          passCount  = 0;
  int          checkCount = 0;

  io_out_port dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wEn      (wEn),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .clrOvf   (clrOvf),
    .count    (count)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports any difference
  task automatic checkField(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Compares every DUT output against what the model says it should be
  task automatic checkOutput();
    int n;
    n = modelQ.size();
    checkField("outValid", 32'(outValid), 32'(n > 0));
    checkField("empty",    32'(empty),    32'(n == 0));
    checkField("full",     32'(full),     32'(n == DEPTH));
    checkField("count",    32'(count),    32'(n));
    checkField("overflow", 32'(overflow), 32'(modelOvf));
    if (n > 0) begin
      checkField("dataOut", 32'(dataOut), 32'(modelQ[0]));
    end
  endtask

  // Drives one cycle of inputs, advances the model past the clock edge,
  // then checks the DUT outputs shortly after the edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] b,
                               input logic rdy, input logic clr);
    bit wasFull;
    bit popNow;
    rst      = r;
    wEn      = w;
    bus      = b;
    outReady = rdy;
    clrOvf   = clr;
    @(posedge clk);
    if (r) begin
      modelQ.delete();
      modelOvf = 1'b0;
    end else begin
      wasFull = (modelQ.size() == DEPTH);
      popNow  = (modelQ.size() > 0) && rdy;
      if (popNow) void'(modelQ.pop_front());
      if (w && !wasFull) modelQ.push_back(b);
      if (clr) modelOvf = 1'b0;
      if (w && wasFull) modelOvf = 1'b1;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    modelOvf = 1'b0;
    rst = 1'b1; wEn = 1'b0; bus = '0; outReady = 1'b0; clrOvf = 1'b0;

    // Reset for two cycles, then idle
    applyStimulus(1, 0, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    checkField("dataOutAfterReset", 32'(dataOut), 32'h0);

    // Single write then three stalled cycles
    applyStimulus(0, 1, 16'hA5A5, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0000, 0, 0);

    // Fill, overflow, drain in order, clear overflow
    applyStimulus(1, 0, 16'h0000, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 16'(i), 0, 0);
    applyStimulus(0, 1, 16'h0005, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 16'h0000, 1, 0);
    applyStimulus(0, 0, 16'h0000, 0, 1);

    // Simultaneous push/pop at count 2 through the pointer wrap
    applyStimulus(0, 1, 16'h0020, 0, 0);
    applyStimulus(0, 1, 16'h0021, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 16'h0010 + 16'(i), 1, 0);

    // Full plus pop in the same cycle: write dropped, overflow set
    applyStimulus(0, 1, 16'h0030, 0, 0);
    applyStimulus(0, 1, 16'h0031, 0, 0);
    applyStimulus(0, 1, 16'hBEEF, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 16'h0000, 1, 0);

    // Clear and set in the same cycle while full: set wins
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h0040 + 16'(i), 0, 0);
    applyStimulus(0, 1, 16'h0050, 0, 1);

    // Reset mid-operation with a write pending
    applyStimulus(0, 0, 16'h0000, 1, 0);
    applyStimulus(1, 1, 16'h1234, 0, 0);
    applyStimulus(0, 0, 16'h0000, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 99) < 60),
                    16'($urandom),
                    ($urandom_range(0, 99) < 50),
                    ($urandom_range(0, 99) < 10));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_io_out_port
